// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// IF stage of the 5-stage pipelined MIPS CPU. It holds the program counter
// and a word-addressed instruction memory that a loader fills through a
// dedicated write port. It produces the registered IF/ID pair (instruction,
// pc+4) that the decode stage consumes.
//
// Stall from hazard detection freezes the PC and IF/ID. A taken branch or
// jump resolved in ID redirects the PC and flushes IF/ID. Fetching HALT_WORD
// freezes fetch until the next reset.
//
// Parameters:
//   IMEM_DEPTH - instruction memory size in 32-bit words (power of two)
//   RESET_PC   - PC value loaded on reset
//   HALT_WORD  - encoding that stops fetch
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   stall         in   hold PC and IF/ID (load-use hazard)
//   branch_taken  in   redirect to branch_target and flush IF/ID
//   branch_target in   redirect byte address (bits [1:0] ignored)
//   imem_we       in   loader write enable
//   imem_waddr    in   loader byte address (bits [1:0] ignored)
//   imem_wdata    in   loader write data
//   instruction   out  IF/ID instruction register
//   pc_out        out  IF/ID pc+4 of that instruction
//   if_valid      out  IF/ID holds a real fetched instruction
//   halted        out  fetch frozen on HALT_WORD
//   stall_cycles  out  (IF_PERF_CNT_EN only) saturating stall-edge count
//   flush_count   out  (IF_PERF_CNT_EN only) saturating flush count
//
// Optional feature: define IF_PERF_CNT_EN to add the two performance
// counters. Without it those ports and counters do not exist.
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter int          IMEM_DEPTH = 512,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        imem_we,
  input  logic [31:0] imem_waddr,
  input  logic [31:0] imem_wdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        if_valid,
  output logic        halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  localparam int AW = $clog2(IMEM_DEPTH);

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] instruction_next;
  logic [31:0] pc_out_next;
  logic        if_valid_next;

  logic [31:0] imem [IMEM_DEPTH];

  logic        fetch_in_range;
  logic        write_in_range;
  logic [31:0] fetch_word;

  // An address is in range when every word-address bit above the memory
  // index is zero; this avoids aliasing high addresses onto low words.
  assign fetch_in_range = (pc[31:AW+2] == '0);
  assign write_in_range = (imem_waddr[31:AW+2] == '0);
  assign fetch_word     = fetch_in_range ? imem[pc[AW+1:2]] : 32'h0000_0000;

  assign halted = (state == HALTED);

  // Loader write port. No reset so that program contents survive a CPU
  // reset; the combinational read above sees the old word on a same-edge
  // write.
  always_ff @(posedge clk) begin
    if (imem_we && write_in_range) begin
      imem[imem_waddr[AW+1:2]] <= imem_wdata;
    end
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      instruction <= 32'h0000_0000;
      pc_out      <= 32'h0000_0000;
      if_valid    <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instruction <= instruction_next;
      pc_out      <= pc_out_next;
      if_valid    <= if_valid_next;
    end
  end

  // Next-state logic. In RUN, a redirect outranks stall so a flushed slot
  // never sticks behind a hazard, and a halt word fetched in a redirect
  // cycle is simply dropped with the rest of the wrong-path fetch.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    instruction_next = instruction;
    pc_out_next      = pc_out;
    if_valid_next    = if_valid;

    case (state)
      RUN: begin
        if (branch_taken) begin
          pc_next          = {branch_target[31:2], 2'b00};
          instruction_next = 32'h0000_0000;
          pc_out_next      = 32'h0000_0000;
          if_valid_next    = 1'b0;
        end else if (stall) begin
          pc_next          = pc;
        end else if (fetch_word == HALT_WORD) begin
          instruction_next = 32'h0000_0000;
          if_valid_next    = 1'b0;
          state_next       = HALTED;
        end else begin
          instruction_next = fetch_word;
          pc_out_next      = pc + 32'd4;
          if_valid_next    = 1'b1;
          pc_next          = pc + 32'd4;
        end
      end
      HALTED: begin
        instruction_next = 32'h0000_0000;
        if_valid_next    = 1'b0;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

`ifdef IF_PERF_CNT_EN
  logic stall_event;
  logic flush_event;

  assign stall_event = (state == RUN) && stall && !branch_taken;
  assign flush_event = (state == RUN) && branch_taken;

  // Saturating performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 32'h0000_0000;
      flush_count  <= 32'h0000_0000;
    end else begin
      if (stall_event && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (flush_event && (flush_count != 32'hFFFF_FFFF)) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed self-checking bench for instruction_fetch. Each scenario task
// drives its stimulus and compares the IF/ID outputs against hand-computed
// values. Inputs change 1 time unit after the rising edge and outputs are
// sampled there as well.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        if_valid;
  logic        halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] W0  = 32'h002A_000A;
  localparam logic [31:0] W1  = 32'h8C22_0004;
  localparam logic [31:0] W2  = 32'h0000_0000;
  localparam logic [31:0] W3  = 32'h1234_5678;
  localparam logic [31:0] W16 = 32'hA5A5_0016;

  instruction_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_we       (imem_we),
    .imem_waddr    (imem_waddr),
    .imem_wdata    (imem_wdata),
    .instruction   (instruction),
    .pc_out        (pc_out),
    .if_valid      (if_valid),
    .halted        (halted)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
    imem_we    = 1'b1;
    imem_waddr = addr;
    imem_wdata = data;
    tick();
    imem_we    = 1'b0;
  endtask

  // Hold reset, fill memory and check the reset values.
  task automatic test_reset();
    load_word(32'h0000_0000, W0);
    load_word(32'h0000_0004, W1);
    load_word(32'h0000_0008, W2);
    load_word(32'h0000_000C, W3);
    load_word(32'h0000_0040, W16);
    checks++;
    if (instruction !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_instr: got %h expected %h", instruction, 32'h0);
    end
    checks++;
    if (pc_out !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_pc_out: got %h expected %h", pc_out, 32'h0);
    end
    checks++;
    if (if_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %b expected 0", if_valid);
    end
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_halted: got %b expected 0", halted);
    end
  endtask

  // First two fetches after reset release.
  task automatic test_fetch();
    reset = 1'b0;
    tick();
    checks++;
    if (instruction !== W0 || pc_out !== 32'd4 || if_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL fetch_e1: got %h/%h/%b expected %h/%h/1", instruction, pc_out, if_valid, W0, 32'd4);
    end
    tick();
    checks++;
    if (instruction !== W1 || pc_out !== 32'd8 || if_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL fetch_e2: got %h/%h/%b expected %h/%h/1", instruction, pc_out, if_valid, W1, 32'd8);
    end
  endtask

  // Three stalled edges hold IF/ID, then fetch continues at PC=8.
  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instruction !== W1 || pc_out !== 32'd8 || if_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL stall_hold%0d: got %h/%h/%b expected %h/%h/1", i, instruction, pc_out, if_valid, W1, 32'd8);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (instruction !== W2 || pc_out !== 32'd12 || if_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_resume: got %h/%h/%b expected %h/%h/1", instruction, pc_out, if_valid, W2, 32'd12);
    end
  endtask

  // Redirect wins over a simultaneous stall; target low bits are dropped.
  task automatic test_branch();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0042;
    stall         = 1'b1;
    tick();
    branch_taken  = 1'b0;
    stall         = 1'b0;
    checks++;
    if (instruction !== 32'h0 || pc_out !== 32'h0 || if_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL branch_flush: got %h/%h/%b expected 0/0/0", instruction, pc_out, if_valid);
    end
    tick();
    checks++;
    if (instruction !== W16 || pc_out !== 32'h44 || if_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL branch_target_fetch: got %h/%h/%b expected %h/%h/1", instruction, pc_out, if_valid, W16, 32'h44);
    end
`ifdef IF_PERF_CNT_EN
    checks++;
    if (flush_count !== 32'd1 || stall_cycles !== 32'd3) begin
      errors++; $display("[TB] FAIL perf_after_branch: got flush=%0d stall=%0d expected flush=1 stall=3", flush_count, stall_cycles);
    end
`endif
  endtask

  // Out-of-range PC fetches zero but still valid; out-of-range writes drop.
  task automatic test_out_of_range();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0800;
    imem_we       = 1'b1;
    imem_waddr    = 32'h0000_0800;
    imem_wdata    = 32'hBAD0_0800;
    tick();
    branch_taken  = 1'b0;
    imem_we       = 1'b0;
    tick();
    checks++;
    if (instruction !== 32'h0 || pc_out !== 32'h804 || if_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL oor_fetch: got %h/%h/%b expected 0/%h/1", instruction, pc_out, if_valid, 32'h804);
    end
`ifdef IF_PERF_CNT_EN
    checks++;
    if (flush_count !== 32'd2 || stall_cycles !== 32'd3) begin
      errors++; $display("[TB] FAIL perf_after_oor: got flush=%0d stall=%0d expected flush=2 stall=3", flush_count, stall_cycles);
    end
`endif
  endtask

  // PC wraps from 0xFFFFFFFC to 0.
  task automatic test_wrap();
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFE;
    tick();
    branch_taken  = 1'b0;
    tick();
    checks++;
    if (instruction !== 32'h0 || pc_out !== 32'h0 || if_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap_top: got %h/%h/%b expected 0/0/1", instruction, pc_out, if_valid);
    end
    tick();
    checks++;
    if (instruction !== W0 || pc_out !== 32'd4 || if_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap_zero: got %h/%h/%b expected %h/4/1", instruction, pc_out, if_valid, W0);
    end
  endtask

  // Reset between edges clears outputs at once; memory survives.
  task automatic test_reset_midrun();
    tick();
    checks++;
    if (instruction !== W1 || pc_out !== 32'd8) begin
      errors++; $display("[TB] FAIL midrun_pc8: got %h/%h expected %h/8", instruction, pc_out, W1);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (instruction !== 32'h0 || pc_out !== 32'h0 || if_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL midrun_async: got %h/%h/%b expected 0/0/0", instruction, pc_out, if_valid);
    end
`ifdef IF_PERF_CNT_EN
    checks++;
    if (flush_count !== 32'd0 || stall_cycles !== 32'd0) begin
      errors++; $display("[TB] FAIL perf_reset: got flush=%0d stall=%0d expected 0/0", flush_count, stall_cycles);
    end
`endif
    reset = 1'b0;
    tick();
    checks++;
    if (instruction !== W0 || pc_out !== 32'd4 || if_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL midrun_restart: got %h/%h/%b expected %h/4/1", instruction, pc_out, if_valid, W0);
    end
  endtask

  // Halt word at imem[3] freezes fetch; only reset leaves HALTED.
  task automatic test_halt();
    reset = 1'b1;
    load_word(32'h0000_000C, 32'hFFFF_FFFF);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (instruction !== W2 || pc_out !== 32'd12 || halted !== 1'b0) begin
      errors++; $display("[TB] FAIL halt_pre: got %h/%h/%b expected %h/12/0", instruction, pc_out, halted, W2);
    end
    tick();
    checks++;
    if (halted !== 1'b1 || if_valid !== 1'b0 || instruction !== 32'h0) begin
      errors++; $display("[TB] FAIL halt_enter: got halted=%b valid=%b instr=%h expected 1/0/0", halted, if_valid, instruction);
    end
    branch_target = 32'h0000_0040;
    stall         = 1'b1;
    for (int i = 0; i < 10; i++) begin
      branch_taken = (i % 2 == 0);
      tick();
      checks++;
      if (halted !== 1'b1 || if_valid !== 1'b0 || instruction !== 32'h0) begin
        errors++; $display("[TB] FAIL halt_hold%0d: got halted=%b valid=%b instr=%h expected 1/0/0", i, halted, if_valid, instruction);
      end
    end
    branch_taken = 1'b0;
    stall        = 1'b0;
`ifdef IF_PERF_CNT_EN
    checks++;
    if (flush_count !== 32'd0 || stall_cycles !== 32'd0) begin
      errors++; $display("[TB] FAIL perf_halted: got flush=%0d stall=%0d expected 0/0", flush_count, stall_cycles);
    end
`endif
    load_word(32'h0000_000C, 32'h1111_1111);
    reset = 1'b1;
    #1;
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("[TB] FAIL halt_reset: got %b expected 0", halted);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (instruction !== 32'h1111_1111 || pc_out !== 32'd16 || if_valid !== 1'b1 || halted !== 1'b0) begin
      errors++; $display("[TB] FAIL halt_write_while_halted: got %h/%h/%b/%b expected 11111111/16/1/0", instruction, pc_out, if_valid, halted);
    end
  endtask

  // Same-edge write and fetch of one word returns the old word.
  task automatic test_read_during_write();
    reset = 1'b1;
    #1;
    reset      = 1'b0;
    imem_we    = 1'b1;
    imem_waddr = 32'h0000_0003;
    imem_wdata = 32'hDEAD_0000;
    tick();
    imem_we = 1'b0;
    checks++;
    if (instruction !== W0 || pc_out !== 32'd4) begin
      errors++; $display("[TB] FAIL rdw_old: got %h/%h expected %h/4", instruction, pc_out, W0);
    end
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0000;
    tick();
    branch_taken  = 1'b0;
    tick();
    checks++;
    if (instruction !== 32'hDEAD_0000 || pc_out !== 32'd4) begin
      errors++; $display("[TB] FAIL rdw_new: got %h/%h expected deadbeef-style %h/4", instruction, pc_out, 32'hDEAD_0000);
    end
  endtask

  initial begin
    reset         = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    imem_we       = 1'b0;
    imem_waddr    = 32'h0;
    imem_wdata    = 32'h0;
    test_reset();
    test_fetch();
    test_stall();
    test_branch();
    test_out_of_range();
    test_wrap();
    test_reset_midrun();
    test_halt();
    test_read_during_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
